abm_burst_scheduler: RTL

- Sequences the burst-master-with-FIFO block. Accepts one long read or write transfer request: op, start address, total beat count.
- Splits the transfer into legal AXI INCR bursts, limited by max burst length and never crossing a BOUNDARY-byte line.
- Issues each burst to the burst master over its start-request/ack handshake and waits for burst completion.
- Accumulates the response status and reports transfer completion to the requester.

---
 rtl/abm_burst_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/abm_burst_scheduler.sv
// Splits one long AXI read/write transfer into INCR bursts that respect the
// maximum burst length and the BOUNDARY address line, then sequences them.
module abm_burst_scheduler #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 128,
  parameter int MAX_BURST_LEN = 256,
  parameter int BOUNDARY      = 4096,
  parameter int BEATS_W       = 16,
  parameter int ABORT_ON_ERR  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xfer_valid,
  output logic              xfer_ready,
  input  logic              xfer_op,
  input  logic [ADDR_W-1:0] xfer_addr,
  input  logic [BEATS_W-1:0] xfer_beats,
  output logic              xfer_done,
  output logic [1:0]        xfer_status,
  output logic              busy,
  output logic [BEATS_W-1:0] bursts_issued,
  output logic              cmd_start_req,
  input  logic              cmd_start_ack,
  output logic              axi_cmd_op,
  output logic [ADDR_W-1:0] axi_cmd_address,
  output logic [7:0]        axi_cmd_burst_len_in,
  input  logic              burst_done,
  input  logic [1:0]        burst_status
);

  localparam int BPB     = DATA_W / 8;
  localparam int BPB_LOG = $clog2(BPB);
  localparam int BND_LOG = $clog2(BOUNDARY);
  localparam int NW      = BEATS_W + 1;
  localparam int CW      = (BND_LOG + 1 > NW) ? BND_LOG + 1 : NW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BEATS_W-1:0] rem_q, rem_d;
  logic [NW-1:0]      n_q, n_d;
  logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
  logic [7:0]         len_q, len_d;
  logic [1:0]         status_q, status_d;
  logic [BEATS_W-1:0] bursts_q, bursts_d;

  logic [CW-1:0]      off_w, to_bnd, n_calc;
  logic [ADDR_W-1:0]  addr_step;
  logic [BEATS_W-1:0] rem_after;

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a,
                                         input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Address is BPB-aligned, so the distance to the line is an exact beat count.
  always_comb begin
    off_w     = CW'(addr_q[BND_LOG-1:0]);
    to_bnd    = (CW'(BOUNDARY) - off_w) >> BPB_LOG;
    n_calc    = min3(CW'(rem_q), CW'(MAX_BURST_LEN), to_bnd);
    addr_step = ADDR_W'(n_q) << BPB_LOG;
    rem_after = rem_q - n_q[BEATS_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    n_d        = n_q;
    cmd_addr_d = cmd_addr_q;
    len_d      = len_q;
    status_d   = status_q;
    bursts_d   = bursts_q;
    case (state_q)
      S_IDLE: begin
        if (xfer_valid) begin
          op_d     = xfer_op;
          addr_d   = xfer_addr & ~ADDR_W'(BPB - 1);
          rem_d    = xfer_beats;
          status_d = 2'b00;
          bursts_d = '0;
          state_d  = (xfer_beats == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        n_d        = n_calc[NW-1:0];
        len_d      = 8'(n_calc - CW'(1));
        cmd_addr_d = addr_q;
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (cmd_start_ack) begin
          bursts_d = bursts_q + 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (burst_done) begin
          if (status_q == 2'b00 && burst_status != 2'b00) status_d = burst_status;
          addr_d = addr_q + addr_step;
          rem_d  = rem_after;
          if (rem_after == '0 || (ABORT_ON_ERR != 0 && burst_status != 2'b00))
            state_d = S_DONE;
          else
            state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      n_q        <= '0;
      cmd_addr_q <= '0;
      len_q      <= '0;
      status_q   <= 2'b00;
      bursts_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      n_q        <= n_d;
      cmd_addr_q <= cmd_addr_d;
      len_q      <= len_d;
      status_q   <= status_d;
      bursts_q   <= bursts_d;
    end
  end

  assign xfer_ready           = (state_q == S_IDLE);
  assign busy                 = (state_q != S_IDLE);
  assign xfer_done            = (state_q == S_DONE);
  assign cmd_start_req        = (state_q == S_REQ);
  assign xfer_status          = status_q;
  assign bursts_issued        = bursts_q;
  assign axi_cmd_op           = op_q;
  assign axi_cmd_address      = cmd_addr_q;
  assign axi_cmd_burst_len_in = len_q;

endmodule
